// File: rtl/tone_detector_pkg.sv
// Shared tone definitions: widths, the tone-index-to-prescale table used by
// both tone generation and tone detection, and the detector FSM states.
package tone_pkg;

  localparam int TONE_W     = 4;
  localparam int PRESCALE_W = 10;
  localparam int NUM_TONES  = 16;

  // Detector states; the encoding is visible on the dbg_state port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_SEARCH  = 2'd2,
    ST_QUALIFY = 2'd3
  } tone_state_t;

  // Prescale value per tone index; the tone period is PRESCALE_DIV * value clocks.
  function automatic logic [PRESCALE_W-1:0] tone_prescale(input logic [TONE_W-1:0] idx);
    logic [PRESCALE_W-1:0] val;
    unique case (idx)
      4'd0:    val = 10'h075;
      4'd1:    val = 10'h06E;
      4'd2:    val = 10'h068;
      4'd3:    val = 10'h062;
      4'd4:    val = 10'h05D;
      4'd5:    val = 10'h058;
      4'd6:    val = 10'h053;
      4'd7:    val = 10'h04E;
      4'd8:    val = 10'h04A;
      4'd9:    val = 10'h045;
      4'd10:   val = 10'h041;
      4'd11:   val = 10'h03E;
      4'd12:   val = 10'h03A;
      4'd13:   val = 10'h037;
      4'd14:   val = 10'h034;
      default: val = 10'h031;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/tone_detector_edge_sync.sv
// edge_sync: two-flop synchroniser for an asynchronous input followed by a
// registered rising-edge pulse. The pulse is high for one clock, three clocks
// after the input edge.
module edge_sync (
  input  logic clk,
  input  logic resetN,
  input  logic async_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  // Synchronise the input, remember the previous level and register the edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/tone_detector.sv
// tone_detector: measures the period of a square-wave audio input in prescale
// ticks and maps it back to the nearest tone index of the shared table.
// Optional build macro TONE_DETECTOR_HYST_EN: while locked, the locked index
// is accepted with a tolerance of TOL+2 ticks so lock survives jitter.
//
// Output semantics: tone_valid is a level (no backpressure); tone_out is only
// meaningful while tone_valid is high; tone_changed is a single-cycle pulse
// when tone_valid rises or tone_out changes while valid.
module tone_detector
  import tone_pkg::*;
#(
  parameter int PRESCALE_DIV  = 256,
  parameter int TOL           = 2,
  parameter int STABLE_CNT    = 3,
  parameter int TIMEOUT_TICKS = 1023
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  enable,
  input  logic                  audio_in,
  output logic [TONE_W-1:0]     tone_out,
  output logic                  tone_valid,
  output logic                  tone_changed,
  output logic [PRESCALE_W-1:0] period_out,
  output logic [1:0]            dbg_state
);

  localparam int DIV_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(PRESCALE_DIV - 1);
  localparam logic [PRESCALE_W-1:0] TIMEOUT_V = PRESCALE_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0]      STABLE_V  = CNT_W'(STABLE_CNT);
  localparam logic [10:0]           TOL_V     = 11'(TOL);
`ifdef TONE_DETECTOR_HYST_EN
  localparam logic [10:0]           TOL_LOCK_V = 11'(TOL + 2);
`endif

  tone_state_t state_q, state_d;

  logic [DIV_W-1:0]      presc_q, presc_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PRESCALE_W-1:0] pout_q, pout_d;
  logic [PRESCALE_W-1:0] meas_q, meas_d;
  logic [TONE_W-1:0]     idx_q, idx_d;
  logic [TONE_W-1:0]     best_idx_q, best_idx_d;
  logic [10:0]           best_diff_q, best_diff_d;
  logic [TONE_W-1:0]     cand_q, cand_d;
  logic [CNT_W-1:0]      stable_q, stable_d;
  logic [TONE_W-1:0]     tone_q, tone_d;
  logic                  valid_q, valid_d;
  logic                  changed_q, changed_d;
`ifdef TONE_DETECTOR_HYST_EN
  logic [10:0]           lock_diff_q, lock_diff_d;
`endif

  logic                  rise;
  logic                  tick;
  logic [PRESCALE_W-1:0] period_inc;
  logic signed [10:0]    diff_s;
  logic [10:0]           diff_abs;
  logic                  match_ok;
  logic [TONE_W-1:0]     match_idx;

  edge_sync u_edge_sync (
    .clk     (clk),
    .resetN  (resetN),
    .async_i (audio_in),
    .rise_o  (rise)
  );

  // Tick on prescaler wrap; the period count includes a tick coinciding with
  // a rise so the latched period is floor(clocks between rises / PRESCALE_DIV).
  assign tick       = (presc_q == DIV_LAST);
  assign period_inc = (tick && (period_q != TIMEOUT_V)) ? period_q + 1'b1 : period_q;

  // Distance between the captured period and the table entry under search.
  assign diff_s   = $signed({1'b0, meas_q}) - $signed({1'b0, tone_prescale(idx_q)});
  assign diff_abs = diff_s[10] ? 11'(-diff_s) : 11'(diff_s);

  // Prescaler and period counter: held at 0 in IDLE, restarted on every rise.
  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    period_d = period_inc;
    pout_d   = pout_q;
    if (!enable || (state_q == ST_IDLE)) begin
      presc_d  = '0;
      period_d = '0;
    end else if (rise) begin
      presc_d  = '0;
      period_d = '0;
      pout_d   = period_inc;
    end
  end

  // FSM next state, table search and lock qualification.
  always_comb begin
    state_d     = state_q;
    meas_d      = meas_q;
    idx_d       = idx_q;
    best_idx_d  = best_idx_q;
    best_diff_d = best_diff_q;
    cand_d      = cand_q;
    stable_d    = stable_q;
    tone_d      = tone_q;
    valid_d     = valid_q;
    changed_d   = 1'b0;
    match_ok    = 1'b0;
    match_idx   = best_idx_q;
`ifdef TONE_DETECTOR_HYST_EN
    lock_diff_d = lock_diff_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (rise) begin
          state_d = ST_SEARCH;
          meas_d  = period_inc;
          idx_d   = '0;
        end else if (period_q == TIMEOUT_V) begin
          state_d  = ST_IDLE;
          valid_d  = 1'b0;
          stable_d = '0;
        end
      end
      ST_SEARCH: begin
        // Strictly smaller replaces, so ties keep the lower index.
        if ((idx_q == '0) || (diff_abs < best_diff_q)) begin
          best_idx_d  = idx_q;
          best_diff_d = diff_abs;
        end
`ifdef TONE_DETECTOR_HYST_EN
        if (idx_q == tone_q) lock_diff_d = diff_abs;
`endif
        idx_d = idx_q + TONE_W'(1);
        if (idx_q == TONE_W'(NUM_TONES - 1)) state_d = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        match_ok  = (best_diff_q <= TOL_V);
        match_idx = best_idx_q;
`ifdef TONE_DETECTOR_HYST_EN
        // The locked tone wins with the wider tolerance while valid.
        if (valid_q && (lock_diff_q <= TOL_LOCK_V)) begin
          match_ok  = 1'b1;
          match_idx = tone_q;
        end
`endif
        if (match_ok && (match_idx == cand_q)) begin
          stable_d = (stable_q == STABLE_V) ? stable_q : stable_q + CNT_W'(1);
        end else if (match_ok) begin
          cand_d   = match_idx;
          stable_d = CNT_W'(1);
        end else begin
          stable_d = '0;
          valid_d  = 1'b0;
        end
        if (match_ok && (stable_d >= STABLE_V)) begin
          tone_d    = match_idx;
          valid_d   = 1'b1;
          changed_d = !valid_q || (tone_q != match_idx);
        end
        state_d = ST_MEASURE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d   = ST_IDLE;
      valid_d   = 1'b0;
      tone_d    = '0;
      stable_d  = '0;
      changed_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      period_q    <= '0;
      pout_q      <= '0;
      meas_q      <= '0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_diff_q <= '0;
      cand_q      <= '0;
      stable_q    <= '0;
      tone_q      <= '0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
`ifdef TONE_DETECTOR_HYST_EN
      lock_diff_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      period_q    <= period_d;
      pout_q      <= pout_d;
      meas_q      <= meas_d;
      idx_q       <= idx_d;
      best_idx_q  <= best_idx_d;
      best_diff_q <= best_diff_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      tone_q      <= tone_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
`ifdef TONE_DETECTOR_HYST_EN
      lock_diff_q <= lock_diff_d;
`endif
    end
  end

  assign tone_out     = tone_q;
  assign tone_valid   = valid_q;
  assign tone_changed = changed_q;
  assign period_out   = pout_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/tone_detector.md
Name: tone_detector

Overview:
- Measures the period of an incoming square-wave audio signal and maps it back to the 4-bit tone index whose prescale value matches.
- It is the inverse of the tone-index-to-prescale lookup used for tone generation, and sits on the audio input path.
- It feeds tone_out / tone_valid to game logic, for example a "play the note back" check.
- Tone period in clk cycles = PRESCALE_DIV × prescale value, so the measured tick count compares directly against the shared table.

Parameters:
- PRESCALE_DIV, 256, clk cycles per measurement tick.
- TOL, 2, maximum |measured − table| in ticks still accepted as a match.
- STABLE_CNT, 3, consecutive identical matches required before the tone is reported.
- TIMEOUT_TICKS, 1023, ticks without a rising edge before lock is dropped (≤ 2^10−1).

Ports:
- clk  in  1  system clock (31.5 MHz).
- resetN  in  1  asynchronous active-low reset.
- enable  in  1  detector run enable; low forces IDLE and clears lock.
- audio_in  in  1  asynchronous square-wave input.
- tone_out  out  4  detected tone index (0..15).
- tone_valid  out  1  high while a tone is locked.
- tone_changed  out  1  one-cycle pulse when tone_valid rises or tone_out changes value while valid.
- period_out  out  10  last completed period in ticks, saturated at TIMEOUT_TICKS.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Input conditioning: audio_in passes a 2-FF synchroniser, then rising-edge detect. rise is valid 3 clk after the physical edge.
- Tick prescaler: counts 0..PRESCALE_DIV−1 and emits tick on wrap. It is cleared on every rise, so period = floor(clocks between rises / PRESCALE_DIV).
- Period counter: 10 bits. It increments on tick and saturates at TIMEOUT_TICKS. On rise it is latched to period_out and cleared.
- FSM states:
  - IDLE: counters held at 0. On rise with enable high → MEASURE.
  - MEASURE: counting.
    - On rise → SEARCH (period latched; the counter restarts at once, so measurement continues concurrently).
    - On counter == TIMEOUT_TICKS → IDLE, tone_valid←0, stable count←0.
  - SEARCH: 16 cycles, idx 0..15, one entry per cycle.
    - Tracks best_idx / best_diff = |period − table[idx]| using 11-bit signed subtraction.
    - Strictly-smaller diff replaces the current best, so on a tie the lower index wins.
    - Then → QUALIFY.
  - QUALIFY: 1 cycle.
    - If best_diff ≤ TOL and best_idx == cand: stable_cnt++ (saturating).
    - Else if best_diff ≤ TOL: cand←best_idx, stable_cnt←1.
    - Else (no match): stable_cnt←0, tone_valid←0.
    - When stable_cnt reaches STABLE_CNT: tone_out←cand, tone_valid←1. tone_changed pulses in the same cycle if valid was 0 or tone_out differed.
    - → MEASURE.
- A rise during SEARCH/QUALIFY cannot occur legitimately (minimum period 49×256 clk ≫ 17 clk). If one does occur, it is ignored for matching; the period counter still restarts.
- enable low: synchronously → IDLE; tone_valid, tone_out, stable_cnt cleared. period_out is held.
- resetN low at any time: immediate return to reset values, including mid-SEARCH.

Optional Feature:
- Macro: TONE_DETECTOR_HYST_EN.
- Defined: while tone_valid, a measurement of the locked tone_out index is accepted with tolerance TOL+2. This holds lock through jitter. Matching other indices still uses TOL.
- Undefined: a single TOL applies everywhere.

Decomposition:
- Package tone_pkg holds:
  - TONE_W=4, PRESCALE_W=10.
  - The 16-entry prescale table constant: 0x75, 0x6E, 0x68, 0x62, 0x5D, 0x58, 0x53, 0x4E, 0x4A, 0x45, 0x41, 0x3E, 0x3A, 0x37, 0x34, 0x31.
  - The FSM state enum.
- The table is the single source for both tone generation and detection.
- Sub-module: edge_sync (2-FF synchroniser plus rising-edge pulse), reusable for other async inputs.

Test Plan:
- Square wave, period 69×256 clk (idx 9) → tone_valid=1, tone_out=9 in QUALIFY after the 4th rise. tone_changed pulses exactly once.
- Period 71×256 → tone_out=9 (diff 2). Period 72×256 → tone_out=8 (diff 2 vs 0x4A=74).
- Period 67×256 (tie between 0x45 and 0x41) → tone_out=9 (lower index wins).
- Period 200×256 → no match: tone_valid stays 0 and period_out=200. After lock on idx 0, switch to idx 15 (49×256) → tone_out=15 after 3 periods, with one tone_changed pulse.
- Lock on idx 5, then hold audio_in constant → tone_valid drops when the counter reaches 1023 ticks. period_out keeps the last completed value of 88 (the idx 5 period).
- Assert resetN low mid-SEARCH → all outputs 0 immediately. Deassert and resend idx 3 → lock after 4 rises.
- With TONE_DETECTOR_HYST_EN defined: lock on 69, then period 73 → stays valid at 9. Without the macro, the same period 73 matches 0x4A, so tone_out becomes 8 after 3 periods.
